dla_output_signature: RTL
=========================

DLA_OUTPUT_SIGNATURE -- requirements
Module: dla_output_signature

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  LANES  4  number of accelerator output lanes
  DATA_W  16  bits per lane word
  WORDS  64  accepted words per frame (>=2)
  SEED  16'hACE1  MISR initial value
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all state on rising edge
  rst  in  1  asynchronous, active-high reset
  i_start  in  1  begin a frame (sampled in IDLE only)
  i_valid  in  LANES  per-lane word valid
  i_data  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]
  o_ready  out  LANES  one-hot grant; lane k accepted when i_valid[k] & o_ready[k]
  o_busy  out  1  high in COLLECT
  o_sig_valid  out  1  one-cycle pulse, signature complete
  o_signature  out  DATA_W  final MISR value, held until next i_start accepted
  o_dummy_out  out  1  XOR-reduce of o_signature

Function
REQ-003 The FSM SHALL have states IDLE, COLLECT, DONE; reset state IDLE.
REQ-004 IDLE -> COLLECT on i_start=1; on that edge MISR<=SEED, word count<=0, RR pointer<=0.
REQ-005 COLLECT -> DONE on the edge that accepts the word with count==WORDS-1; otherwise remain.
REQ-006 DONE -> IDLE unconditionally after one cycle; o_sig_valid=1 only in DONE.
REQ-007 i_start outside IDLE SHALL be ignored; no frame restart.
REQ-008 o_ready SHALL be all-zero outside COLLECT.
REQ-009 In COLLECT, o_ready SHALL be combinational one-hot: first lane with i_valid=1 searching from pointer p upward, wrapping at LANES-1 to 0; all-zero if no lane valid.
REQ-010 On accept from lane g, pointer SHALL become (g+1) mod LANES; unchanged when no accept.
REQ-011 At most one word SHALL be accepted per cycle; a granted lane's word is consumed that edge, no buffering.
REQ-012 MISR update per accepted word d: fb = m[15]^m[13]^m[12]^m[10]; m <= {m[14:0],fb} ^ d (DATA_W=16; for other widths taps at DATA_W-1,-3,-4,-6).
REQ-013 Count SHALL increment by 1 per accepted word; no wrap within a frame; width clog2(WORDS)+1.
REQ-014 o_signature SHALL load the post-update MISR on the final-accept edge, so o_signature and o_sig_valid are valid together in DONE, one cycle after the final accept (latency 1).
REQ-015 o_busy SHALL equal (state==COLLECT).
REQ-016 Lanes not granted SHALL see o_ready[k]=0 and keep i_valid/i_data stable (source responsibility); block does not drop held words.

Reset
REQ-017 rst=1 SHALL asynchronously force: state IDLE, MISR=SEED, count=0, pointer=0, o_signature=0, o_sig_valid=0, o_ready=0, o_busy=0, o_dummy_out=0.
REQ-018 rst asserted mid-COLLECT SHALL abandon the frame with no o_sig_valid pulse; after release the block waits in IDLE for i_start.
REQ-019 Reset release SHALL be synchronous-safe: first state change only on a clk edge with rst=0.

Verification
REQ-020 Reset: assert rst mid-cycle, no clk -> all outputs 0 immediately; o_ready=0 with i_valid=4'hF.
REQ-021 Single lane: start, i_valid=4'b0001, data=16'h0000 for 64 words -> o_ready[0]=1 each cycle, o_sig_valid one cycle after 64th accept, o_signature equals 64 zero-input MISR steps from 16'hACE1 (model), o_busy low in DONE.
REQ-022 Round robin: all lanes valid continuously -> grant order 0,1,2,3,0,...; 64 accepts in exactly 64 cycles; each lane 16 accepts.
REQ-023 Sparse: i_valid=4'b1010 -> grants alternate 1,3,1,3; lanes 0,2 never granted; count advances only on accepts.
REQ-024 Start ignored: pulse i_start at word 10 -> no MISR/count reset; signature matches uninterrupted model.
REQ-025 Abort: rst at word 30, then new frame -> no o_sig_valid from first frame; second frame signature matches fresh model from SEED.

Source files
------------

// File: rtl/dla_output_signature.sv
// Output-signature collector: round-robin arbitration over accelerator output lanes,
// folding each accepted word into a MISR and publishing the result once per frame.
module dla_output_signature #(
  parameter int                LANES  = 4,
  parameter int                DATA_W = 16,
  parameter int                WORDS  = 64,
  parameter logic [DATA_W-1:0] SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic [LANES-1:0]         i_valid,
  input  logic [LANES*DATA_W-1:0]  i_data,
  output logic [LANES-1:0]         o_ready,
  output logic                     o_busy,
  output logic                     o_sig_valid,
  output logic [DATA_W-1:0]        o_signature,
  output logic                     o_dummy_out
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W = $clog2(WORDS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);
  localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   misr_q, misr_d;
  logic [DATA_W-1:0]   sig_q, sig_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic [LANES-1:0]    grant;
  logic [PTR_W-1:0]    grant_idx;
  logic                accept;
  logic [DATA_W-1:0]   grant_data;
  logic [DATA_W-1:0]   misr_next;
  logic [PTR_W:0]      search_sum;
  logic [PTR_W-1:0]    search_idx;

  // Taps at DATA_W-1, -3, -4, -6 give x^16+x^14+x^13+x^11+1 for the 16-bit case.
  function automatic logic [DATA_W-1:0] misr_step(input logic [DATA_W-1:0] m,
                                                  input logic [DATA_W-1:0] d);
    logic fb;
    fb = m[DATA_W-1] ^ m[DATA_W-3] ^ m[DATA_W-4] ^ m[DATA_W-6];
    return {m[DATA_W-2:0], fb} ^ d;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_advance(input logic [PTR_W-1:0] g);
    return (g == LAST_LANE) ? '0 : g + 1'b1;
  endfunction

  // Round-robin search starting at ptr_q; the first valid lane found wins.
  always_comb begin
    grant      = '0;
    grant_idx  = '0;
    accept     = 1'b0;
    search_sum = '0;
    search_idx = '0;
    if (state_q == COLLECT) begin
      for (int i = 0; i < LANES; i++) begin
        search_sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
        if (search_sum >= (PTR_W+1)'(LANES)) begin
          search_sum = search_sum - (PTR_W+1)'(LANES);
        end
        search_idx = search_sum[PTR_W-1:0];
        if (!accept && i_valid[search_idx]) begin
          accept            = 1'b1;
          grant[search_idx] = 1'b1;
          grant_idx         = search_idx;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (grant[k]) begin
        grant_data = i_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign misr_next = misr_step(misr_q, grant_data);

  always_comb begin
    state_d = state_q;
    misr_d  = misr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = COLLECT;
          misr_d  = SEED;
          cnt_d   = '0;
          ptr_d   = '0;
        end
      end
      COLLECT: begin
        if (accept) begin
          misr_d = misr_next;
          cnt_d  = cnt_q + 1'b1;
          ptr_d  = ptr_advance(grant_idx);
          // Signature is captured on the same edge as the final word so it lines up with DONE.
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            sig_d   = misr_next;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      misr_q  <= SEED;
      sig_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      misr_q  <= misr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_ready     = grant;
  assign o_busy      = (state_q == COLLECT);
  assign o_sig_valid = (state_q == DONE);
  assign o_signature = sig_q;
  assign o_dummy_out = ^sig_q;

endmodule
